// File: rtl/ee457_pcpu_ctrl_pipe.sv
// rtl/ee457_pcpu_ctrl_pipe.sv - pipelined CPU control: decode, control bundle pipeline, load-use stall FSM, flush
// Carries the decoded control bundle ID -> EX -> MEM -> WB and inserts load-use bubbles.
module ee457_pcpu_ctrl_pipe #(
    parameter int unsigned RA_W      = 5,
    parameter int unsigned LU_STALLS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             flush,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [1:0]       ex_aluop,
    output logic             ex_alusrc,
    output logic             ex_rdst,
    output logic             ex_link,
    output logic [5:0]       ex_func,
    output logic             mem_mr,
    output logic             mem_mw,
    output logic             mem_branch,
    output logic             mem_bne,
    output logic             mem_jmp,
    output logic             mem_jr,
    output logic             wb_regw,
    output logic             wb_mtor,
    output logic [RA_W-1:0]  wb_dst,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] F_JR     = 6'b001000;

    typedef struct packed {
        logic regw;
        logic mtor;
        logic [RA_W-1:0] dst;
    } wb_t;

    typedef struct packed {
        logic mr;
        logic mw;
        logic branch;
        logic bne;
        logic jmp;
        logic jr;
    } mem_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       rdst;
        logic       link;
        logic [5:0] func;
        mem_t       m;
        wb_t        w;
    } ctrl_t;

    typedef struct packed {
        mem_t m;
        wb_t  w;
    } exmem_t;

    typedef enum logic {IDLE, STALL} state_t;

    ctrl_t            dec;
    ctrl_t            idex_q;
    exmem_t           exmem_q;
    wb_t              memwb_q;
    state_t           state_q, state_d;
    logic [1:0]       scnt_q, scnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             uses_rt, known, haz, stall, stall_raw;

    always_comb begin
        dec     = '0;
        uses_rt = 1'b0;
        known   = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.aluop = 2'b10;
                dec.rdst  = 1'b1;
                uses_rt   = 1'b1;
                if (func == F_JR) dec.m.jr   = 1'b1;
                else              dec.w.regw = 1'b1;
            end
            OP_LW: begin
                dec.w.regw = 1'b1; dec.alusrc = 1'b1; dec.m.mr = 1'b1; dec.w.mtor = 1'b1;
            end
            OP_SW: begin
                dec.alusrc = 1'b1; dec.m.mw = 1'b1; uses_rt = 1'b1;
            end
            OP_BEQ: begin
                dec.aluop = 2'b01; dec.m.branch = 1'b1; uses_rt = 1'b1;
            end
            OP_BNE: begin
                dec.aluop = 2'b01; dec.m.branch = 1'b1; dec.m.bne = 1'b1; uses_rt = 1'b1;
            end
            OP_J:    dec.m.jmp = 1'b1;
            OP_JAL: begin
                dec.m.jmp = 1'b1; dec.w.regw = 1'b1; dec.link = 1'b1;
            end
            OP_ADDI: begin
                dec.w.regw = 1'b1; dec.alusrc = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // Unknown opcodes leave the whole bundle zero, including func and dst.
        if (known) begin
            dec.func  = func;
            dec.w.dst = dec.link ? RA_W'(31) : (dec.rdst ? id_rd : id_rt);
        end
        if (dec.w.dst == '0) dec.w.regw = 1'b0;
    end

    assign haz = (state_q == IDLE) && idex_q.m.mr && (idex_q.w.dst != '0) &&
                 ((idex_q.w.dst == id_rs) || ((idex_q.w.dst == id_rt) && uses_rt));

    // scnt holds the stall cycles still owed after the current one.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        stall_raw = 1'b0;
        if (flush) begin
            state_d = IDLE;
            scnt_d  = 2'd0;
        end else if (state_q == STALL) begin
            stall_raw = 1'b1;
            if (scnt_q <= 2'd1) begin
                state_d = IDLE;
                scnt_d  = 2'd0;
            end else begin
                scnt_d = scnt_q - 2'd1;
            end
        end else if (haz) begin
            stall_raw = 1'b1;
            scnt_d    = 2'(LU_STALLS - 1);
            if (LU_STALLS > 1) state_d = STALL;
        end
    end

    assign stall = stall_raw && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scnt_q      <= 2'd0;
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            idex_q  <= (stall || flush) ? '0 : dec;
            exmem_q <= '{m: idex_q.m, w: idex_q.w};
            memwb_q <= exmem_q.w;
            if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign pc_write   = !stall;
    assign ifid_write = !stall;
    assign ex_aluop   = idex_q.aluop;
    assign ex_alusrc  = idex_q.alusrc;
    assign ex_rdst    = idex_q.rdst;
    assign ex_link    = idex_q.link;
    assign ex_func    = idex_q.func;
    assign mem_mr     = exmem_q.m.mr;
    assign mem_mw     = exmem_q.m.mw;
    assign mem_branch = exmem_q.m.branch;
    assign mem_bne    = exmem_q.m.bne;
    assign mem_jmp    = exmem_q.m.jmp;
    assign mem_jr     = exmem_q.m.jr;
    assign wb_regw    = memwb_q.regw;
    assign wb_mtor    = memwb_q.mtor;
    assign wb_dst     = memwb_q.dst;
    assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_ee457_pcpu_ctrl_pipe.sv
// tb/tb_ee457_pcpu_ctrl_pipe.sv - vector and sequence bench for the pipelined control unit
module tb_ee457_pcpu_ctrl_pipe;
    logic       clk = 1'b0;
    logic       rst, flush;
    logic [5:0] op, func;
    logic [4:0] id_rs, id_rt, id_rd;

    always #5 clk = ~clk;

    logic [1:0]  a_ex_aluop, b_ex_aluop;
    logic        a_ex_alusrc, a_ex_rdst, a_ex_link, b_ex_alusrc, b_ex_rdst, b_ex_link;
    logic [5:0]  a_ex_func, b_ex_func;
    logic        a_mem_mr, a_mem_mw, a_mem_branch, a_mem_bne, a_mem_jmp, a_mem_jr;
    logic        b_mem_mr, b_mem_mw, b_mem_branch, b_mem_bne, b_mem_jmp, b_mem_jr;
    logic        a_wb_regw, a_wb_mtor, b_wb_regw, b_wb_mtor;
    logic [4:0]  a_wb_dst, b_wb_dst;
    logic        a_pc_write, a_ifid_write, b_pc_write, b_ifid_write;
    logic [15:0] a_stall_cnt;
    logic [3:0]  b_stall_cnt;

    ee457_pcpu_ctrl_pipe #(.RA_W(5), .LU_STALLS(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .op(op), .func(func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .ex_aluop(a_ex_aluop), .ex_alusrc(a_ex_alusrc), .ex_rdst(a_ex_rdst), .ex_link(a_ex_link),
        .ex_func(a_ex_func), .mem_mr(a_mem_mr), .mem_mw(a_mem_mw), .mem_branch(a_mem_branch),
        .mem_bne(a_mem_bne), .mem_jmp(a_mem_jmp), .mem_jr(a_mem_jr), .wb_regw(a_wb_regw),
        .wb_mtor(a_wb_mtor), .wb_dst(a_wb_dst), .stall_cnt(a_stall_cnt)
    );

    ee457_pcpu_ctrl_pipe #(.RA_W(5), .LU_STALLS(3), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .op(op), .func(func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .ex_aluop(b_ex_aluop), .ex_alusrc(b_ex_alusrc), .ex_rdst(b_ex_rdst), .ex_link(b_ex_link),
        .ex_func(b_ex_func), .mem_mr(b_mem_mr), .mem_mw(b_mem_mw), .mem_branch(b_mem_branch),
        .mem_bne(b_mem_bne), .mem_jmp(b_mem_jmp), .mem_jr(b_mem_jr), .wb_regw(b_wb_regw),
        .wb_mtor(b_wb_mtor), .wb_dst(b_wb_dst), .stall_cnt(b_stall_cnt)
    );

    wire [10:0] a_ex  = {a_ex_aluop, a_ex_alusrc, a_ex_rdst, a_ex_link, a_ex_func};
    wire [5:0]  a_mem = {a_mem_mr, a_mem_mw, a_mem_branch, a_mem_bne, a_mem_jmp, a_mem_jr};
    wire [6:0]  a_wb  = {a_wb_regw, a_wb_mtor, a_wb_dst};
    wire [10:0] b_ex  = {b_ex_aluop, b_ex_alusrc, b_ex_rdst, b_ex_link, b_ex_func};

    localparam logic [5:0]  NOP_OP  = 6'b111111;
    localparam logic [10:0] EX_ADD  = {2'b10, 1'b0, 1'b1, 1'b0, 6'b100000};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs, rt, rd;
        logic [10:0] e_ex;
        logic [5:0]  e_mem;
        logic [6:0]  e_wb;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        op = o; func = f; id_rs = s; id_rt = t; id_rd = d;
    endtask

    task automatic filler;
        set_in(NOP_OP, 6'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        filler();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, EX_ADD, 6'b000000, {2'b10, 5'd3}};
        vecs[1]  = '{6'b100011, 6'd0, 5'd1, 5'd8, 5'd5, {2'b00, 3'b100, 6'd0}, 6'b100000, {2'b11, 5'd8}};
        vecs[2]  = '{6'b101011, 6'd0, 5'd1, 5'd7, 5'd0, {2'b00, 3'b100, 6'd0}, 6'b010000, {2'b00, 5'd7}};
        vecs[3]  = '{6'b000100, 6'd0, 5'd1, 5'd4, 5'd0, {2'b01, 3'b000, 6'd0}, 6'b001000, {2'b00, 5'd4}};
        vecs[4]  = '{6'b000101, 6'd0, 5'd1, 5'd4, 5'd0, {2'b01, 3'b000, 6'd0}, 6'b001100, {2'b00, 5'd4}};
        vecs[5]  = '{6'b000010, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 6'b000010, 7'd0};
        vecs[6]  = '{6'b000011, 6'd0, 5'd0, 5'd5, 5'd6, {2'b00, 3'b001, 6'd0}, 6'b000010, {2'b10, 5'd31}};
        vecs[7]  = '{6'b001000, 6'd0, 5'd1, 5'd9, 5'd0, {2'b00, 3'b100, 6'd0}, 6'b000000, {2'b10, 5'd9}};
        vecs[8]  = '{6'b000000, 6'b001000, 5'd31, 5'd0, 5'd0, {2'b10, 3'b010, 6'b001000}, 6'b000001, 7'd0};
        vecs[9]  = '{6'b000000, 6'b100000, 5'd1, 5'd2, 5'd0, EX_ADD, 6'b000000, 7'd0};
        vecs[10] = '{NOP_OP, 6'b100000, 5'd1, 5'd5, 5'd6, 11'd0, 6'b000000, 7'd0};
        vecs[11] = '{6'b000000, 6'b100010, 5'd4, 5'd5, 5'd6, {2'b10, 3'b010, 6'b100010}, 6'b000000, {2'b10, 5'd6}};
        vecs[12] = '{6'b001000, 6'd0, 5'd1, 5'd0, 5'd0, {2'b00, 3'b100, 6'd0}, 6'b000000, 7'd0};

        flush = 1'b0;
        rst   = 1'b1;
        filler();
        tick();
        tick();
        chk("reset_ex", a_ex, 0);
        chk("reset_mem", a_mem, 0);
        chk("reset_wb", a_wb, 0);
        chk("reset_pc_write", a_pc_write, 1);
        chk("reset_ifid_write", a_ifid_write, 1);
        chk("reset_stall_cnt", a_stall_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].op, vecs[i].func, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            tick();
            chk($sformatf("vec%0d_ex", i), a_ex, vecs[i].e_ex);
            filler();
            tick();
            chk($sformatf("vec%0d_mem", i), a_mem, vecs[i].e_mem);
            tick();
            chk($sformatf("vec%0d_wb", i), a_wb, vecs[i].e_wb);
        end

        // Load-use, single bubble
        do_reset();
        set_in(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0);
        tick();
        set_in(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3);
        #1;
        chk("lu1_pc_write", a_pc_write, 0);
        chk("lu1_ifid_write", a_ifid_write, 0);
        tick();
        chk("lu1_bubble_ex", a_ex, 0);
        #1;
        chk("lu1_pc_release", a_pc_write, 1);
        tick();
        chk("lu1_add_ex", a_ex, EX_ADD);
        chk("lu1_bubble_mem", a_mem, 0);
        chk("lu1_lw_wb", a_wb, {2'b11, 5'd8});
        filler();
        tick();
        chk("lu1_bubble_wb", a_wb, 0);
        tick();
        chk("lu1_add_wb", a_wb, {2'b10, 5'd3});
        chk("lu1_stall_cnt", a_stall_cnt, 1);

        // Load to r0 never stalls
        set_in(6'b100011, 6'd0, 5'd1, 5'd0, 5'd0);
        tick();
        set_in(6'b000000, 6'b100000, 5'd0, 5'd2, 5'd3);
        #1;
        chk("r0_no_stall", a_pc_write, 1);
        tick();
        chk("r0_add_ex", a_ex, EX_ADD);

        // Load-use, three bubbles
        do_reset();
        set_in(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0);
        tick();
        set_in(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (!b_pc_write) cnt++;
            tick();
        end
        chk("lu3_hold_cycles", cnt, 3);
        chk("lu3_stall_cnt", b_stall_cnt, 3);

        // Flush in the hazard cycle
        do_reset();
        set_in(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0);
        tick();
        set_in(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3);
        flush = 1'b1;
        #1;
        chk("flush_haz_pc_write", a_pc_write, 1);
        tick();
        flush = 1'b0;
        chk("flush_haz_ex", a_ex, 0);
        chk("flush_haz_stall_cnt", a_stall_cnt, 0);
        filler();

        // Flush in the second cycle of a three-cycle stall
        do_reset();
        set_in(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0);
        tick();
        set_in(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3);
        #1;
        chk("flush_st_c1_pc", b_pc_write, 0);
        tick();
        flush = 1'b1;
        #1;
        chk("flush_st_c2_pc", b_pc_write, 1);
        tick();
        flush = 1'b0;
        filler();
        #1;
        chk("flush_st_after_pc", b_pc_write, 1);
        chk("flush_st_ex", b_ex, 0);
        chk("flush_st_stall_cnt", b_stall_cnt, 1);

        // Reset in the middle of a stall
        do_reset();
        set_in(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0);
        tick();
        set_in(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_pc_during", b_pc_write, 1);
        tick();
        rst = 1'b0;
        filler();
        #1;
        chk("rst_mid_pc_after", b_pc_write, 1);
        chk("rst_mid_stall_cnt", b_stall_cnt, 0);
        chk("rst_mid_ex", b_ex, 0);

        // Saturation of a 4-bit counter: 7 hazards x 3 bubbles
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_in(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0);
            tick();
            set_in(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3);
            repeat (4) tick();
            if (k == 3) chk("sat_mid_count", b_stall_cnt, 12);
        end
        chk("sat_hold", b_stall_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
